mtimer_nch: RTL



---
 rtl/mtimer_nch.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mtimer_nch.sv
// mtimer_nch: prescaled free-running machine timer with NCH compare channels.
//
// A single counter of CNT_W bits advances once every PSC+1 cycles while
// enabled. Each channel compares the counter against its own compare value.
// The compare result is handled in one of three ways:
//   level     : the pending bit follows the compare result directly.
//   one-shot  : the pending bit latches once per arming.
//   periodic  : the pending bit latches, and the compare value advances by
//               PER on every cycle that still matches.
// Registers are reached through a word-addressed CSR port.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   csr_we_i      write strobe, sampled at the clk edge
//   csr_addr_i    word address
//   csr_wdata_i   write data
//   csr_rdata_o   read data, a combinational mux of csr_addr_i
//   halt_i        debug halt; freezes counting when CTRL.HFRZ=1
//   irq_o         per-channel interrupt (IP & IE), registered
//   irq_any_o     OR of all channel interrupts, registered

// Per-channel compare, mode, and pending logic.
module mtimer_ch #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic             cmp_lo_we,
    input  logic             cmp_hi_we,
    input  logic             mode_we,
    input  logic             per_we,
    input  logic             ip_w1c,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] cmp,
    output logic [31:0]      per,
    output logic [1:0]       mode,
    output logic             armed,
    output logic             ip
);
    logic ip_q;
    logic match;
    logic oneshot;
    logic periodic;
    logic set;

    assign match    = (cnt >= cmp);
    assign oneshot  = (mode == 2'd1);
    assign periodic = (mode == 2'd2);
    assign set      = (oneshot & armed & match) | (periodic & match);

    // Level mode (and reserved mode 3) exposes the raw compare result.
    assign ip = (oneshot | periodic) ? ip_q : match;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp   <= '1;
            per   <= '0;
            mode  <= '0;
            armed <= 1'b0;
            ip_q  <= 1'b0;
        end else begin
            if (per_we)
                per <= wdata;

            // A CSR write wins over the periodic reload and touches only one half.
            if (cmp_lo_we)
                cmp <= {cmp[CNT_W-1:32], wdata};
            else if (cmp_hi_we)
                cmp <= CNT_W'({wdata, cmp[31:0]});
            else if (periodic & match)
                cmp <= cmp + CNT_W'(per);

            if (mode_we) begin
                mode  <= wdata[1:0];
                armed <= (wdata[1:0] == 2'd1);
            end else if (oneshot & armed & match) begin
                armed <= 1'b0;
            end

            // A mode change drops a pending bit latched under the old mode.
            // Otherwise a new set wins over a W1C on the same edge.
            if (mode_we && (wdata[1:0] != mode))
                ip_q <= 1'b0;
            else
                ip_q <= (ip_q & ~ip_w1c) | set;
        end
    end
endmodule

module mtimer_nch #(
    parameter int CNT_W  = 64,
    parameter int NCH    = 4,
    parameter int PSC_W  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_we_i,
    input  logic [ADDR_W-1:0] csr_addr_i,
    input  logic [31:0]       csr_wdata_i,
    output logic [31:0]       csr_rdata_o,
    input  logic              halt_i,
    output logic [NCH-1:0]    irq_o,
    output logic              irq_any_o
);
    logic [CNT_W-1:0] cnt;
    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] psc_cnt;
    logic             en;
    logic             hfrz;
    logic [NCH-1:0]   ie;

    logic [NCH-1:0][CNT_W-1:0] cmp;
    logic [NCH-1:0][63:0]      cmp_ext;
    logic [NCH-1:0][31:0]      per;
    logic [NCH-1:0][1:0]       mode;
    logic [NCH-1:0]            armed;
    logic [NCH-1:0]            ip;
    logic [63:0]               cnt_ext;

    logic ctrl_we, psc_we, cnt_lo_we, cnt_hi_we, ip_we, ie_we;
    logic clr, run, tick;

    assign ctrl_we   = csr_we_i && (csr_addr_i == ADDR_W'(0));
    assign psc_we    = csr_we_i && (csr_addr_i == ADDR_W'(1));
    assign cnt_lo_we = csr_we_i && (csr_addr_i == ADDR_W'(2));
    assign cnt_hi_we = csr_we_i && (csr_addr_i == ADDR_W'(3));
    assign ip_we     = csr_we_i && (csr_addr_i == ADDR_W'(4));
    assign ie_we     = csr_we_i && (csr_addr_i == ADDR_W'(5));

    assign clr  = ctrl_we & csr_wdata_i[1];
    assign run  = en & ~(hfrz & halt_i);
    assign tick = run & (psc_cnt == psc);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            psc_cnt <= '0;
            psc     <= '0;
            en      <= 1'b0;
            hfrz    <= 1'b0;
            ie      <= '0;
        end else begin
            if (ctrl_we) begin
                en   <= csr_wdata_i[0];
                hfrz <= csr_wdata_i[2];
            end
            if (psc_we)
                psc <= csr_wdata_i[PSC_W-1:0];
            if (ie_we)
                ie <= csr_wdata_i[NCH-1:0];

            if (psc_we | clr | tick)
                psc_cnt <= '0;
            else if (run)
                psc_cnt <= psc_cnt + PSC_W'(1);

            // A direct counter write beats CLR, and CLR beats the tick.
            if (cnt_lo_we)
                cnt <= {cnt[CNT_W-1:32], csr_wdata_i};
            else if (cnt_hi_we)
                cnt <= CNT_W'({csr_wdata_i, cnt[31:0]});
            else if (clr)
                cnt <= '0;
            else if (tick)
                cnt <= cnt + CNT_W'(1);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        mtimer_ch #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cnt       (cnt),
            .cmp_lo_we (csr_we_i && (csr_addr_i == ADDR_W'(8 + 2*c))),
            .cmp_hi_we (csr_we_i && (csr_addr_i == ADDR_W'(9 + 2*c))),
            .mode_we   (csr_we_i && (csr_addr_i == ADDR_W'(24 + c))),
            .per_we    (csr_we_i && (csr_addr_i == ADDR_W'(32 + c))),
            .ip_w1c    (ip_we & csr_wdata_i[c]),
            .wdata     (csr_wdata_i),
            .cmp       (cmp[c]),
            .per       (per[c]),
            .mode      (mode[c]),
            .armed     (armed[c]),
            .ip        (ip[c])
        );
        assign cmp_ext[c] = 64'(cmp[c]);
    end

    assign cnt_ext = 64'(cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_o     <= '0;
            irq_any_o <= 1'b0;
        end else begin
            irq_o     <= ip & ie;
            irq_any_o <= |(ip & ie);
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_W'(0): csr_rdata_o = {29'b0, hfrz, 1'b0, en};
            ADDR_W'(1): csr_rdata_o = 32'(psc);
            ADDR_W'(2): csr_rdata_o = cnt_ext[31:0];
            ADDR_W'(3): csr_rdata_o = cnt_ext[63:32];
            ADDR_W'(4): csr_rdata_o = 32'(ip);
            ADDR_W'(5): csr_rdata_o = 32'(ie);
            default:    csr_rdata_o = '0;
        endcase
        for (int c = 0; c < NCH; c++) begin
            if (csr_addr_i == ADDR_W'(8 + 2*c))  csr_rdata_o = cmp_ext[c][31:0];
            if (csr_addr_i == ADDR_W'(9 + 2*c))  csr_rdata_o = cmp_ext[c][63:32];
            if (csr_addr_i == ADDR_W'(24 + c))   csr_rdata_o = {29'b0, armed[c], mode[c]};
            if (csr_addr_i == ADDR_W'(32 + c))   csr_rdata_o = per[c];
        end
    end
endmodule
